// File: rtl/incr_stim_checker_if.sv
// Stimulus/response bundle between the increment checker and the increment DUT.
// The checker (master) drives the DUT reset and inputs and samples the DUT outputs.
interface incr_stim_checker_if;
  logic        dut_reset_l;
  logic [1:0]  drv_small;
  logic [39:0] drv_quad;
  logic [69:0] drv_wide;
  logic [1:0]  mon_small;
  logic [39:0] mon_quad;
  logic [69:0] mon_wide;

  modport master (
    output dut_reset_l, drv_small, drv_quad, drv_wide,
    input  mon_small, mon_quad, mon_wide
  );

  modport slave (
    input  dut_reset_l, drv_small, drv_quad, drv_wide,
    output mon_small, mon_quad, mon_wide
  );
endinterface

// File: rtl/incr_stim_checker.sv
// Stimulus generator and response checker for the increment datapath.
// Holds the DUT in reset for two cycles, drives NUM_VECTORS vectors (all ones,
// all zeros, then LFSR-derived), and compares each response against in+1 per
// field after LAT cycles. Reports done/pass, a saturating error count and the
// index of the first mismatch.
module incr_stim_checker #(
  parameter int          NUM_VECTORS = 50,
  parameter int          LAT         = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                start,
  incr_stim_checker_if.master dut,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         first_err_idx
);

  typedef enum logic [2:0] {S_IDLE, S_RST_DUT, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [1:0]  hold_small_q, hold_small_d;
  logic [39:0] hold_quad_q, hold_quad_d;
  logic [69:0] hold_wide_q, hold_wide_d;
  logic [15:0] err_q, err_d;
  logic [15:0] first_q, first_d;

  logic [1:0]  gen_small;
  logic [39:0] gen_quad;
  logic [69:0] gen_wide;
  logic        cur_vld;
  logic [1:0]  chk_small;
  logic [39:0] chk_quad;
  logic [69:0] chk_wide;
  logic [15:0] chk_idx;
  logic        chk_vld;
  logic        mm;
  logic [15:0] mm_idx;

  // 32-bit Fibonacci LFSR, taps 32,22,2,1
  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Vector for the current index: wrap pattern, zero pattern, then LFSR fill
  always_comb begin
    gen_small = lfsr_q[1:0];
    gen_quad  = {lfsr_q[7:0], lfsr_q};
    gen_wide  = {lfsr_q[5:0], lfsr_q, lfsr_q};
    if (idx_q == 16'd0) begin
      gen_small = '1;
      gen_quad  = '1;
      gen_wide  = '1;
    end else if (idx_q == 16'd1) begin
      gen_small = '0;
      gen_quad  = '0;
      gen_wide  = '0;
    end
  end

  assign cur_vld = (state_q == S_RUN);

  // Expected responses and indices delayed to line up with the DUT latency
  generate
    if (LAT == 0) begin : g_nolat
      assign chk_vld   = cur_vld;
      assign chk_small = gen_small + 2'd1;
      assign chk_quad  = gen_quad + 40'd1;
      assign chk_wide  = gen_wide + 70'd1;
      assign chk_idx   = idx_q;
    end else begin : g_lat
      logic [LAT-1:0] pv_q;
      logic [1:0]     ps_q [LAT];
      logic [39:0]    pq_q [LAT];
      logic [69:0]    pw_q [LAT];
      logic [15:0]    pi_q [LAT];

      // Valid shift register; cleared on reset so an aborted run leaves nothing in flight
      always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= cur_vld;
          for (int i = 1; i < LAT; i++) pv_q[i] <= pv_q[i-1];
        end
      end

      // Expected-value and index shift register
      always_ff @(posedge clk) begin
        ps_q[0] <= gen_small + 2'd1;
        pq_q[0] <= gen_quad + 40'd1;
        pw_q[0] <= gen_wide + 70'd1;
        pi_q[0] <= idx_q;
        for (int i = 1; i < LAT; i++) begin
          ps_q[i] <= ps_q[i-1];
          pq_q[i] <= pq_q[i-1];
          pw_q[i] <= pw_q[i-1];
          pi_q[i] <= pi_q[i-1];
        end
      end

      assign chk_vld   = pv_q[LAT-1];
      assign chk_small = ps_q[LAT-1];
      assign chk_quad  = pq_q[LAT-1];
      assign chk_wide  = pw_q[LAT-1];
      assign chk_idx   = pi_q[LAT-1];
    end
  endgenerate

  // Per-cycle mismatch: DUT outputs must be zero while held in reset
  always_comb begin
    mm     = 1'b0;
    mm_idx = chk_idx;
    if (state_q == S_RST_DUT) begin
      mm     = (dut.mon_small != '0) || (dut.mon_quad != '0) || (dut.mon_wide != '0);
      mm_idx = 16'hFFFE;
    end else if (chk_vld) begin
      mm = (dut.mon_small != chk_small) || (dut.mon_quad != chk_quad) ||
           (dut.mon_wide != chk_wide);
    end
  end

  // Next-state, counters, LFSR and error bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    hold_small_d = hold_small_q;
    hold_quad_d  = hold_quad_q;
    hold_wide_d  = hold_wide_q;
    err_d        = err_q;
    first_d      = first_q;

    if (mm) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0)    first_d = mm_idx;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RST_DUT;
          cnt_d        = '0;
          idx_d        = '0;
          lfsr_d       = SEED;
          err_d        = '0;
          first_d      = 16'hFFFF;
          hold_small_d = '0;
          hold_quad_d  = '0;
          hold_wide_d  = '0;
        end
      end
      S_RST_DUT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        hold_small_d = gen_small;
        hold_quad_d  = gen_quad;
        hold_wide_d  = gen_wide;
        idx_d        = idx_q + 16'd1;
        if (idx_q >= 16'd2) lfsr_d = lfsr_next(lfsr_q);
        if (idx_q == 16'(NUM_VECTORS - 1)) begin
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(LAT - 1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any run
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      lfsr_q       <= SEED;
      hold_small_q <= '0;
      hold_quad_q  <= '0;
      hold_wide_q  <= '0;
      err_q        <= '0;
      first_q      <= 16'hFFFF;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      hold_small_q <= hold_small_d;
      hold_quad_q  <= hold_quad_d;
      hold_wide_q  <= hold_wide_d;
      err_q        <= err_d;
      first_q      <= first_d;
    end
  end

  assign dut.dut_reset_l = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_DONE);
  assign dut.drv_small   = cur_vld ? gen_small : hold_small_q;
  assign dut.drv_quad    = cur_vld ? gen_quad  : hold_quad_q;
  assign dut.drv_wide    = cur_vld ? gen_wide  : hold_wide_q;

  assign busy          = (state_q == S_RST_DUT) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == 16'd0);
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_incr_stim_checker.sv
// Bench for incr_stim_checker: a LAT=0 and a LAT=2 instance, each facing a
// behavioural increment DUT whose behaviour is selected per run.
module tb_incr_stim_checker;
  logic clk = 1'b0;
  logic reset_l;
  logic start;

  always #5 clk = ~clk;

  incr_stim_checker_if if0();
  incr_stim_checker_if if2();

  logic        busy0, done0, pass0, busy2, done2, pass2;
  logic [15:0] err0, first0, err2, first2;

  incr_stim_checker #(.NUM_VECTORS(50), .LAT(0), .SEED(32'hACE1_2468)) u0 (
    .clk(clk), .reset_l(reset_l), .start(start), .dut(if0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(first0)
  );

  incr_stim_checker #(.NUM_VECTORS(50), .LAT(2), .SEED(32'hACE1_2468)) u2 (
    .clk(clk), .reset_l(reset_l), .start(start), .dut(if2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_idx(first2)
  );

  // DUT model modes for u0: 0 ideal, 1 identity, 2 bit69 fault at idx7,
  // 3 two-stage delayed ideal, 4 nonzero output while held in reset
  int m0;
  int k;
  int total = 0;
  int bad   = 0;

  // Vector index seen by the DUT: cycles since its reset was released
  always @(posedge clk or negedge reset_l) begin
    if (!reset_l)               k <= 0;
    else if (!if0.dut_reset_l)  k <= 0;
    else                        k <= k + 1;
  end

  logic [1:0]  a1s, a2s, b1s, b2s;
  logic [39:0] a1q, a2q, b1q, b2q;
  logic [69:0] a1w, a2w, b1w, b2w;

  always @(posedge clk) begin
    if (!if0.dut_reset_l) begin
      a1s <= '0; a2s <= '0; a1q <= '0; a2q <= '0; a1w <= '0; a2w <= '0;
    end else begin
      a1s <= if0.drv_small + 2'd1; a2s <= a1s;
      a1q <= if0.drv_quad + 40'd1; a2q <= a1q;
      a1w <= if0.drv_wide + 70'd1; a2w <= a1w;
    end
    if (!if2.dut_reset_l) begin
      b1s <= '0; b2s <= '0; b1q <= '0; b2q <= '0; b1w <= '0; b2w <= '0;
    end else begin
      b1s <= if2.drv_small + 2'd1; b2s <= b1s;
      b1q <= if2.drv_quad + 40'd1; b2q <= b1q;
      b1w <= if2.drv_wide + 70'd1; b2w <= b1w;
    end
  end

  always_comb begin
    if0.mon_small = '0;
    if0.mon_quad  = '0;
    if0.mon_wide  = '0;
    if (if0.dut_reset_l) begin
      case (m0)
        1: begin
          if0.mon_small = if0.drv_small;
          if0.mon_quad  = if0.drv_quad;
          if0.mon_wide  = if0.drv_wide;
        end
        3: begin
          if0.mon_small = a2s;
          if0.mon_quad  = a2q;
          if0.mon_wide  = a2w;
        end
        default: begin
          if0.mon_small = if0.drv_small + 2'd1;
          if0.mon_quad  = if0.drv_quad + 40'd1;
          if0.mon_wide  = if0.drv_wide + 70'd1;
          if (m0 == 2 && k == 7) if0.mon_wide[69] = ~if0.mon_wide[69];
        end
      endcase
    end else if (m0 == 4) begin
      if0.mon_small = 2'd1;
    end
  end

  always_comb begin
    if2.mon_small = '0;
    if2.mon_quad  = '0;
    if2.mon_wide  = '0;
    if (if2.dut_reset_l) begin
      if2.mon_small = b2s;
      if2.mon_quad  = b2q;
      if2.mon_wide  = b2w;
    end
  end

  logic [1:0]  s_a [50], s_b [50];
  logic [39:0] q_a [50], q_b [50];
  logic [69:0] w_a [50], w_b [50];
  int nrec;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then count cycles to done for both instances while
  // recording the vectors u0 drives during RUN
  task automatic do_run(input int mode, input bit rec_b, output int n0, output int n2);
    m0 = mode;
    nrec = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n0 = -1;
    n2 = -1;
    for (int c = 1; c <= 200 && (n0 < 0 || n2 < 0); c++) begin
      @(negedge clk);
      if (if0.dut_reset_l && busy0 && nrec < 50) begin
        if (rec_b) begin
          s_b[nrec] = if0.drv_small; q_b[nrec] = if0.drv_quad; w_b[nrec] = if0.drv_wide;
        end else begin
          s_a[nrec] = if0.drv_small; q_a[nrec] = if0.drv_quad; w_a[nrec] = if0.drv_wide;
        end
        nrec++;
      end
      if (n0 < 0 && done0) n0 = c;
      if (n2 < 0 && done2) n2 = c;
    end
  endtask

  int n0, n2, diffs;

  initial begin
    reset_l = 1'b0;
    start   = 1'b0;
    m0      = 0;
    #12;
    chk("rst_busy",  busy0, 1'b0);
    chk("rst_done",  done0, 1'b0);
    chk("rst_pass",  pass0, 1'b0);
    chk("rst_err",   err0, 16'h0);
    chk("rst_first", first0, 16'hFFFF);
    chk("rst_dutrst", if0.dut_reset_l, 1'b0);
    chk("rst_small", if0.drv_small, 2'd0);
    chk("rst_quad",  if0.drv_quad, 40'd0);
    chk("rst_wide",  if0.drv_wide, 70'd0);
    chk("rst_first2", first2, 16'hFFFF);
    @(negedge clk) reset_l = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: ideal DUT
    do_run(0, 1'b0, n0, n2);
    chk("t1_latency", n0, 52);
    chk("t1_nrec",    nrec, 50);
    chk("t1_pass",    pass0, 1'b1);
    chk("t1_err",     err0, 16'd0);
    chk("t1_first",   first0, 16'hFFFF);
    chk("t1_busy",    busy0, 1'b0);
    chk("t1_v0_small", s_a[0], 2'b11);
    chk("t1_v0_quad",  q_a[0], 40'hFF_FFFF_FFFF);
    chk("t1_v0_wide",  w_a[0], {70{1'b1}});
    chk("t1_v1_quad",  q_a[1], 40'd0);
    chk("t1_v1_wide",  w_a[1], 70'd0);
    chk("t1_v2_quad",  q_a[2], 40'h68_ACE1_2468);
    chk("t1_v2_wide",  w_a[2], 70'h28_ACE1_2468_ACE1_2468);
    chk("t1_v2_small", s_a[2], 2'd0);
    chk("t1_v3_quad",  q_a[3], 40'hD0_59C2_48D0);
    chk("t1_v3_wide",  w_a[3], 70'h10_59C2_48D0_59C2_48D0);
    chk("t1_hold_wide", if0.drv_wide, w_a[49]);
    chk("t1_lat2_latency", n2, 54);
    chk("t1_lat2_pass",    pass2, 1'b1);

    // Test 2: identity DUT, every vector wrong
    do_run(1, 1'b1, n0, n2);
    chk("t2_err",   err0, 16'd50);
    chk("t2_first", first0, 16'd0);
    chk("t2_pass",  pass0, 1'b0);

    // Test 3: single wide-field bit flip at idx 7
    do_run(2, 1'b1, n0, n2);
    chk("t3_err",   err0, 16'd1);
    chk("t3_first", first0, 16'd7);
    chk("t3_pass",  pass0, 1'b0);

    // Test 4: two-stage delayed DUT against LAT=2 (u2) and LAT=0 (u0)
    do_run(3, 1'b1, n0, n2);
    chk("t4_lat2_pass",    pass2, 1'b1);
    chk("t4_lat2_err",     err2, 16'd0);
    chk("t4_lat2_latency", n2, 54);
    chk("t4_lat0_pass",    pass0, 1'b0);
    chk("t4_lat0_errnz",   (err0 != 16'd0), 1'b1);

    // Test 5: DUT outputs nonzero while held in reset
    do_run(4, 1'b1, n0, n2);
    chk("t5_err",   err0, 16'd2);
    chk("t5_first", first0, 16'hFFFE);
    chk("t5_pass",  pass0, 1'b0);

    // Test 6: abort at idx 20, then a clean run repeats test 1
    m0 = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 100 && k != 20; c++) @(negedge clk);
    chk("t6_reach_idx20", k, 20);
    #1 reset_l = 1'b0;
    #1;
    chk("t6_abort_busy",   busy0, 1'b0);
    chk("t6_abort_done",   done0, 1'b0);
    chk("t6_abort_err",    err0, 16'd0);
    chk("t6_abort_first",  first0, 16'hFFFF);
    chk("t6_abort_dutrst", if0.dut_reset_l, 1'b0);
    chk("t6_abort_wide",   if0.drv_wide, 70'd0);
    chk("t6_abort_busy2",  busy2, 1'b0);
    @(negedge clk) reset_l = 1'b1;
    @(negedge clk);
    do_run(0, 1'b1, n0, n2);
    diffs = 0;
    for (int i = 0; i < 50; i++)
      if (s_a[i] !== s_b[i] || q_a[i] !== q_b[i] || w_a[i] !== w_b[i]) diffs++;
    chk("t6_nrec",    nrec, 50);
    chk("t6_vectors", diffs, 0);
    chk("t6_latency", n0, 52);
    chk("t6_pass",    pass0, 1'b1);
    chk("t6_first",   first0, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
